instr_fetch: RTL and testbench



---
 rtl/instr_fetch_if.sv | 17 +
 rtl/instr_fetch.sv | 97 +++++++++
 tb/tb_instr_fetch.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch bus between instr_fetch and the instruction memory.
//   imem_addr  : fetch address (master -> slave)
//   imem_req   : fetch request (master -> slave)
//   imem_valid : returned word valid this cycle (slave -> master)
//   imem_rdata : returned instruction word (slave -> master)
interface instr_fetch_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
);
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_req;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_addr, imem_req, input imem_valid, imem_rdata);
  modport slave  (input imem_addr, imem_req, output imem_valid, imem_rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch/decode stage: holds the PC, fetches over the imem bus,
// latches the word into IR and splits it into control-path fields.
//   clk, rst     : clock, asynchronous active-high reset
//   imem         : fetch bus (master side)
//   nia          : 1 = next PC is PC+1, 0 = jump to IR[ADDR_W-1:0]
//   stall        : holds the DECODE state
//   pc           : address of the instruction in IR
//   instr_valid  : IR fields valid (DECODE)
//   opfn/rs/rt/rd/imm : IR fields
//   halted       : halt instruction reached; only rst leaves HALT
module instr_fetch #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_if.master       imem,
  input  logic                nia,
  input  logic                stall,
  output logic [ADDR_W-1:0]   pc,
  output logic                instr_valid,
  output logic [4:0]          opfn,
  output logic [2:0]          rs,
  output logic [2:0]          rt,
  output logic [2:0]          rd,
  output logic [4:0]          imm,
  output logic                halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    HALT   = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;

  // State, PC and IR registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc_q  <= ADDR_W'(RESET_PC);
      ir_q  <= '0;
    end else begin
      state <= state_d;
      pc_q  <= pc_d;
      ir_q  <= ir_d;
    end
  end

  // Next-state, next-PC and IR capture
  always_comb begin
    state_d = state;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem.imem_valid) begin
          ir_d    = imem.imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!stall) begin
          if (ir_q[15:13] == 3'b111) begin
            state_d = HALT;
          end else begin
            // PC+1 wraps naturally at ADDR_W bits; jump target is truncated
            pc_d    = nia ? pc_q + ADDR_W'(1) : ir_q[ADDR_W-1:0];
            state_d = FETCH;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from state so reset clears them without a clock
  assign imem.imem_addr = pc_q;
  assign imem.imem_req  = (state == FETCH);
  assign instr_valid    = (state == DECODE);
  assign halted         = (state == HALT);
  assign pc             = pc_q;

  assign opfn = ir_q[15:11];
  assign rs   = ir_q[10:8];
  assign rt   = ir_q[7:5];
  assign rd   = ir_q[4:2];
  assign imm  = ir_q[4:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, jump, wait/stall,
// PC wrap, halt and asynchronous reset in FETCH and DECODE.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic       nia, stall;
  logic [7:0] pc, pc2;
  logic       instr_valid, instr_valid2;
  logic [4:0] opfn, opfn2, imm, imm2;
  logic [2:0] rs, rt, rd, rs2, rt2, rd2;
  logic       halted, halted2;

  int npass  = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(8), .INSTR_W(16)) imem1 ();
  instr_fetch_if #(.ADDR_W(8), .INSTR_W(16)) imem2 ();

  instr_fetch #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .imem(imem1), .nia(nia), .stall(stall),
    .pc(pc), .instr_valid(instr_valid), .opfn(opfn), .rs(rs), .rt(rt),
    .rd(rd), .imm(imm), .halted(halted)
  );

  instr_fetch #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(255)) dut_wrap (
    .clk(clk), .rst(rst2), .imem(imem2), .nia(nia), .stall(stall),
    .pc(pc2), .instr_valid(instr_valid2), .opfn(opfn2), .rs(rs2), .rt(rt2),
    .rd(rd2), .imm(imm2), .halted(halted2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in FETCH; returns in the following FETCH (or HALT for halt words)
  task automatic fetch_decode(input logic [15:0] word, input logic [7:0] addr, input logic nia_v);
    chk("fetch_req", 32'(imem1.imem_req), 32'd1);
    chk("fetch_addr", 32'(imem1.imem_addr), 32'(addr));
    chk("fetch_iv", 32'(instr_valid), 32'd0);
    imem1.imem_valid = 1'b1;
    imem1.imem_rdata = word;
    nia = nia_v;
    step();
    imem1.imem_valid = 1'b0;
    chk("dec_iv", 32'(instr_valid), 32'd1);
    chk("dec_req", 32'(imem1.imem_req), 32'd0);
    chk("dec_pc", 32'(pc), 32'(addr));
    chk("dec_opfn", 32'(opfn), 32'(word[15:11]));
    step();
  endtask

  // Asserts rst asynchronously, checks outputs before any edge, then restarts
  task automatic reset_dut();
    rst = 1'b1;
    #1;
    chk("rst_req", 32'(imem1.imem_req), 32'd0);
    chk("rst_iv", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_opfn", 32'(opfn), 32'd0);
    step();
    rst = 1'b0;
    chk("idle_req", 32'(imem1.imem_req), 32'd0);
    step();
  endtask

  initial begin
    rst = 1'b1;
    rst2 = 1'b1;
    nia = 1'b1;
    stall = 1'b0;
    imem1.imem_valid = 1'b0;
    imem1.imem_rdata = '0;
    imem2.imem_valid = 1'b0;
    imem2.imem_rdata = '0;
    step();
    step();
    reset_dut();

    // Sequential fetch, opfn 0, zero wait states
    fetch_decode(16'h0123, 8'd0, 1'b1);
    fetch_decode(16'h0245, 8'd1, 1'b1);
    fetch_decode(16'h0367, 8'd2, 1'b1);
    fetch_decode(16'h0489, 8'd3, 1'b1);
    chk("seq_addr4", 32'(imem1.imem_addr), 32'h04);

    // Reset while in FETCH
    reset_dut();

    // Jump at address 2 to 0x20
    fetch_decode(16'h0001, 8'd0, 1'b1);
    fetch_decode(16'h0002, 8'd1, 1'b1);
    fetch_decode(16'hA020, 8'd2, 1'b0);

    // Memory wait of 3 cycles at 0x20
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", 32'(imem1.imem_req), 32'd1);
      chk("wait_addr", 32'(imem1.imem_addr), 32'h20);
      step();
    end
    chk("wait_req4", 32'(imem1.imem_req), 32'd1);
    imem1.imem_valid = 1'b1;
    imem1.imem_rdata = 16'h1234;
    step();

    // Stall 4 cycles; late imem_valid and nia=0 must be ignored
    imem1.imem_rdata = 16'hFFFF;
    nia = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        stall = 1'b0;
        nia = 1'b1;
        imem1.imem_valid = 1'b0;
      end
      chk("stall_iv", 32'(instr_valid), 32'd1);
      chk("stall_req", 32'(imem1.imem_req), 32'd0);
      chk("stall_pc", 32'(pc), 32'h20);
      chk("stall_opfn", 32'(opfn), 32'h02);
      chk("stall_rs", 32'(rs), 32'd2);
      chk("stall_rt", 32'(rt), 32'd1);
      chk("stall_rd", 32'(rd), 32'd5);
      chk("stall_imm", 32'(imm), 32'h14);
      step();
    end
    chk("post_stall_iv", 32'(instr_valid), 32'd0);
    chk("post_stall_addr", 32'(imem1.imem_addr), 32'h21);

    // Reset while in DECODE
    imem1.imem_valid = 1'b1;
    imem1.imem_rdata = 16'h5000;
    step();
    imem1.imem_valid = 1'b0;
    chk("dec2_opfn", 32'(opfn), 32'h0A);
    chk("dec2_pc", 32'(pc), 32'h21);
    reset_dut();

    // Halt at address 1
    fetch_decode(16'h0001, 8'd0, 1'b1);
    chk("halt_fetch_addr", 32'(imem1.imem_addr), 32'd1);
    imem1.imem_valid = 1'b1;
    imem1.imem_rdata = 16'hE000;
    step();
    imem1.imem_valid = 1'b0;
    chk("halt_dec_opfn", 32'(opfn), 32'h1C);
    step();
    for (int i = 0; i < 3; i++) begin
      imem1.imem_valid = (i == 1);
      imem1.imem_rdata = 16'h0000;
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_req", 32'(imem1.imem_req), 32'd0);
      chk("halt_iv", 32'(instr_valid), 32'd0);
      chk("halt_pc", 32'(pc), 32'd1);
      chk("halt_opfn", 32'(opfn), 32'h1C);
      step();
    end
    imem1.imem_valid = 1'b0;
    reset_dut();
    chk("restart_req", 32'(imem1.imem_req), 32'd1);
    chk("restart_addr", 32'(imem1.imem_addr), 32'd0);

    // PC wrap from 0xFF
    rst2 = 1'b0;
    chk("wrap_idle_req", 32'(imem2.imem_req), 32'd0);
    step();
    chk("wrap_req", 32'(imem2.imem_req), 32'd1);
    chk("wrap_addr0", 32'(imem2.imem_addr), 32'hFF);
    imem2.imem_valid = 1'b1;
    imem2.imem_rdata = 16'h0800;
    nia = 1'b1;
    step();
    imem2.imem_valid = 1'b0;
    chk("wrap_iv", 32'(instr_valid2), 32'd1);
    chk("wrap_pc", 32'(pc2), 32'hFF);
    chk("wrap_opfn", 32'(opfn2), 32'h01);
    step();
    chk("wrap_addr1", 32'(imem2.imem_addr), 32'h00);
    chk("wrap_req1", 32'(imem2.imem_req), 32'd1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
